// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
// Shares one byte-wide synchronous-read memory port between the fetch (I)
// and load (D) requesters. Requests are granted round-robin and expanded into
// consecutive little-endian byte reads. Bytes are merged into a zero-extended
// word that is returned as a single-cycle response pulse to the owner.
module riscv_mem_arbiter #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_MEM     = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req_valid,
  input  logic [WORD_LENGTH-1:0] i_req_addr,
  output logic                   i_req_ready,
  output logic                   i_rsp_valid,
  output logic [WORD_LENGTH-1:0] i_rsp_data,
  output logic                   i_rsp_err,
  input  logic                   d_req_valid,
  input  logic [WORD_LENGTH-1:0] d_req_addr,
  input  logic [1:0]             d_req_size,
  output logic                   d_req_ready,
  output logic                   d_rsp_valid,
  output logic [WORD_LENGTH-1:0] d_rsp_data,
  output logic                   d_rsp_err,
  output logic                   mem_en,
  output logic [WORD_LENGTH-1:0] mem_addr,
  input  logic [7:0]             mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_next;

  logic [WORD_LENGTH-1:0] base;
  logic [1:0]             last_idx;
  logic [1:0]             cnt;
  logic                   owner_d;
  logic                   err_acc;
  logic [WORD_LENGTH-1:0] result;
  logic                   pend_en;
  logic [1:0]             pend_idx;
  logic                   last_d;

  logic                   grant_i;
  logic                   grant_d;
  logic [WORD_LENGTH-1:0] byte_addr;
  logic                   byte_ok;
  logic [WORD_LENGTH-1:0] merged;
  logic [1:0]             d_last_idx;

  // Byte address for the current issue slot; wraps modulo 2^WORD_LENGTH.
  // The merged word folds in the byte read one cycle earlier, if it was issued.
  always_comb begin
    byte_addr = base + WORD_LENGTH'(cnt);
    byte_ok   = (byte_addr < WORD_LENGTH'(NUM_MEM));
    merged    = result;
    if (pend_en) begin
      merged = result | (WORD_LENGTH'(mem_rdata) << {pend_idx, 3'b000});
    end
    case (d_req_size)
      2'd0:    d_last_idx = 2'd0;
      2'd1:    d_last_idx = 2'd1;
      default: d_last_idx = 2'd3;
    endcase
  end

  // Next-state logic, grant decision and memory/response strobes.
  always_comb begin
    state_next  = state;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    mem_en      = 1'b0;
    mem_addr    = '0;
    i_rsp_valid = 1'b0;
    d_rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (i_req_valid && (!d_req_valid || last_d)) begin
            grant_i = 1'b1;
          end else if (d_req_valid) begin
            grant_d = 1'b1;
          end
        end
        if (grant_i || grant_d) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_en   = byte_ok;
        mem_addr = byte_addr;
        if (cnt == last_idx) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = RESP;
      end
      RESP: begin
        i_rsp_valid = !owner_d;
        d_rsp_valid = owner_d;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request capture, byte assembly and response data holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      base       <= '0;
      last_idx   <= '0;
      cnt        <= '0;
      owner_d    <= 1'b0;
      err_acc    <= 1'b0;
      result     <= '0;
      pend_en    <= 1'b0;
      pend_idx   <= '0;
      last_d     <= 1'b1;
      i_rsp_data <= '0;
      i_rsp_err  <= 1'b0;
      d_rsp_data <= '0;
      d_rsp_err  <= 1'b0;
    end else begin
      pend_en  <= 1'b0;
      pend_idx <= cnt;
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            base     <= grant_i ? i_req_addr : d_req_addr;
            last_idx <= grant_i ? 2'd3 : d_last_idx;
            owner_d  <= grant_d;
            err_acc  <= grant_d && (d_req_size == 2'd3);
            result   <= '0;
            cnt      <= '0;
            last_d   <= grant_d;
          end
        end
        ISSUE: begin
          pend_en <= byte_ok;
          cnt     <= cnt + 2'd1;
          result  <= merged;
          if (!byte_ok) begin
            err_acc <= 1'b1;
          end
        end
        DRAIN: begin
          result <= merged;
          if (owner_d) begin
            d_rsp_data <= merged;
            d_rsp_err  <= err_acc;
          end else begin
            i_rsp_data <= merged;
            i_rsp_err  <= err_acc;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Sequencer and arbiter that shares one byte-wide, synchronous-read program memory port between the instruction-fetch path (I) and the data-load path (D) of the core. It accepts word or sub-word read requests through valid/ready handshakes and grants between the two requesters round-robin. Each request is expanded into consecutive little-endian byte reads, and the block returns the assembled, zero-extended result as a one-cycle response pulse.

## Interface
- WORD_LENGTH, 32, data and address width
- NUM_MEM, 4096, memory size in bytes; valid byte addresses are 0..NUM_MEM-1
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req_valid  in  1  fetch request
- i_req_addr  in  WORD_LENGTH  fetch byte address; always a 4-byte read
- i_req_ready  out  1  fetch request accepted this cycle
- i_rsp_valid  out  1  fetch response pulse
- i_rsp_data  out  WORD_LENGTH  fetched word
- i_rsp_err  out  1  out-of-range flag, qualified by i_rsp_valid
- d_req_valid  in  1  load request
- d_req_addr  in  WORD_LENGTH  load byte address
- d_req_size  in  2  0=byte, 1=half, 2=word, 3=word and flag error
- d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err  out  1/1/WORD_LENGTH/1  same meaning as the I-side ports
- mem_en  out  1  byte read strobe
- mem_addr  out  WORD_LENGTH  byte address
- mem_rdata  in  8  byte read data, valid in the cycle after mem_en

## Operation
- FSM states:
  - IDLE: accepts requests.
  - ISSUE: issues N byte reads, where N = 1, 2 or 4 (the I side is always 4).
  - DRAIN: captures the last byte.
  - RESP: drives the response pulse, then returns to IDLE.
- Only IDLE accepts requests. i_req_ready and d_req_ready are combinational: high only in IDLE, not in reset, for the granted requester. Both are never high together.
- Grant:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not served last wins. A priority bit records the last served side.
  - The priority bit resets to favour I.
- On the handshake, the block latches base address, N, owner and the error state (size==3).
- Byte k (k=0..N-1) is read from address base+k, computed modulo 2^WORD_LENGTH. It lands in result bits [8k+7:8k]. Upper bits are zero; the load unit sign-extends.
- Out of range:
  - Any byte with base+k >= NUM_MEM (including wrapped addresses) is not issued; mem_en stays low that cycle.
  - That byte reads as 0x00 and sets the error flag.
  - Byte cycle timing is unchanged.
- Misaligned addresses are legal and handled byte-wise.
- Response:
  - Only the owner's rsp_valid pulses, for exactly one cycle in RESP, with data and err.
  - There is no response back-pressure.
  - rsp_data and rsp_err hold their last value otherwise.
- A requester may raise or drop valid at any time while not granted. There is no queuing; a dropped request is simply not served.

## Timing
- All outputs are reset to 0 and the FSM goes to IDLE. Outputs are 0 in the cycle following rst high.
- Handshake in cycle T (valid & ready):
  - mem_en/mem_addr for byte k are driven in cycle T+1+k.
  - mem_rdata for byte k is sampled at the end of cycle T+2+k.
  - DRAIN occupies cycle T+N+1.
  - rsp_valid is high in cycle T+N+2.
  - The next handshake can occur no earlier than cycle T+N+3.
- Latency from handshake to response: word 6 cycles, half 4, byte 3. Peak throughput is one word per 7 cycles.
- Simultaneous valid in IDLE: exactly one grant per the priority bit. The loser's ready stays low until its turn.
- Reset asserted mid-transaction:
  - The in-flight request is dropped and no response is issued.
  - mem_en is 0 from the next cycle.
  - The priority bit returns to favour I.
- mem_addr is don't-care when mem_en=0 and is driven to 0 in IDLE.

## Test plan
- Word fetch: preload bytes 0x13,0x05,0x10,0x00 at 0x100; I request 0x100 in cycle T. Required: mem_addr 0x100..0x103 in T+1..T+4, i_rsp_valid only at T+6 with i_rsp_data=0x00100513 and err=0.
- Contention: I and D both valid continuously from reset; D byte 0x7 holds 0xAB. Required: grant order I, D, I, D; D responses data=0x000000AB at T+3 relative to each D handshake.
- Misaligned half: D size=1 at 0x3FF with 0x3FF=0x34, 0x400=0x12. Required: d_rsp_data=0x00001234 at T+4, err=0.
- Boundary: I request at NUM_MEM-2 (0xFFE) with bytes 0x11,0x22. Required: mem_en only in T+1 and T+2; i_rsp_data=0x00002211, i_rsp_err=1 at T+6. Address 0xFFFFFFFF also gives err=1.
- Size 3: D request of size 3 at 0x0. Required: a 4-byte read and d_rsp_err=1.
- Reset mid-operation: rst high in T+3 of a word fetch. Required: no i_rsp_valid, mem_en=0 from T+4, all outputs 0. After rst drops, a simultaneous I/D request grants I first.
